// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, ALUOp encodings and the decoded control bundle.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b010011;
  localparam logic [5:0] OP_LW    = 6'b011000;
  localparam logic [5:0] OP_SW    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b011001;
  localparam logic [5:0] OP_BNE   = 6'b011010;
  localparam logic [5:0] OP_J     = 6'b001100;

  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'b000,
    ALUOP_RTYPE = 3'b010,
    ALUOP_JMP   = 3'b011,
    ALUOP_BR    = 3'b100
  } aluop_e;

  typedef struct packed {
    aluop_e aluop;
    logic   aluSrc;
    logic   regDst;
    logic   regWrite;
    logic   jump;
    logic   branch;
    logic   brType;
    logic   memRead;
    logic   memWrite;
    logic   memToReg;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decoder: control bundle, rt-usage flag and illegal-opcode flag.
module ctrl_decode
  import cpu_pkg::*;
#(
  parameter int unsigned OP_W = 6
) (
  input  logic [OP_W-1:0] op,
  output ctrl_t           ctrl,
  output logic            usesRt,
  output logic            illegal
);

  always_comb begin
    ctrl    = '0;
    usesRt  = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl.aluop    = ALUOP_RTYPE;
        ctrl.regDst   = 1'b1;
        ctrl.regWrite = 1'b1;
        usesRt        = 1'b1;
      end
      OP_ADDI: begin
        ctrl.aluop    = ALUOP_ADD;
        ctrl.aluSrc   = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      OP_LW: begin
        ctrl.aluop    = ALUOP_ADD;
        ctrl.aluSrc   = 1'b1;
        ctrl.regWrite = 1'b1;
        ctrl.memRead  = 1'b1;
        ctrl.memToReg = 1'b1;
      end
      OP_SW: begin
        ctrl.aluop    = ALUOP_ADD;
        ctrl.aluSrc   = 1'b1;
        ctrl.memWrite = 1'b1;
        usesRt        = 1'b1;
      end
      OP_BEQ: begin
        ctrl.aluop  = ALUOP_BR;
        ctrl.branch = 1'b1;
        usesRt      = 1'b1;
      end
      OP_BNE: begin
        ctrl.aluop  = ALUOP_BR;
        ctrl.branch = 1'b1;
        ctrl.brType = 1'b1;
        usesRt      = 1'b1;
      end
      OP_J: begin
        ctrl.aluop  = ALUOP_JMP;
        ctrl.aluSrc = 1'b1;
        ctrl.jump   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// ID-stage control unit: opcode decode, load-use hazard detection and the ID/EX control register.
module decode_ctrl_stage
  import cpu_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               id_valid_i,
  input  logic [OP_W-1:0]    id_op_i,
  input  logic [RADDR_W-1:0] id_rs_i,
  input  logic [RADDR_W-1:0] id_rt_i,
  input  logic [RADDR_W-1:0] id_rd_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               ex_valid_o,
  output logic [ALUOP_W-1:0] ex_aluop_o,
  output logic               ex_alusrc_o,
  output logic               ex_regwrite_o,
  output logic               ex_jump_o,
  output logic               ex_branch_o,
  output logic               ex_brtype_o,
  output logic               ex_memread_o,
  output logic               ex_memwrite_o,
  output logic               ex_memtoreg_o,
  output logic [RADDR_W-1:0] ex_rt_o,
  output logic [RADDR_W-1:0] ex_wreg_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  ctrl_t decCtrl;
  logic  decUsesRt;
  logic  decIllegal;
  logic  hz;
  logic  loadBubble;

  ctrl_decode #(.OP_W(OP_W)) uDecode (
    .op      (id_op_i),
    .ctrl    (decCtrl),
    .usesRt  (decUsesRt),
    .illegal (decIllegal)
  );

  // Register $zero is never a real dependency, so a zero ex_rt_o can never stall.
  always_comb begin
    hz = id_valid_i & ex_valid_o & ex_memread_o & (ex_rt_o != '0) &
         ((ex_rt_o == id_rs_i) | (decUsesRt & (ex_rt_o == id_rt_i)));
    stall_o    = hz & ~flush_i;
    loadBubble = flush_i | hz | ~id_valid_i | decIllegal;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_o    <= 1'b0;
      ex_aluop_o    <= '0;
      ex_alusrc_o   <= 1'b0;
      ex_regwrite_o <= 1'b0;
      ex_jump_o     <= 1'b0;
      ex_branch_o   <= 1'b0;
      ex_brtype_o   <= 1'b0;
      ex_memread_o  <= 1'b0;
      ex_memwrite_o <= 1'b0;
      ex_memtoreg_o <= 1'b0;
      ex_rt_o       <= '0;
      ex_wreg_o     <= '0;
      illegal_o     <= 1'b0;
      stall_cnt_o   <= '0;
    end else begin
      if (loadBubble) begin
        ex_valid_o    <= 1'b0;
        ex_aluop_o    <= '0;
        ex_alusrc_o   <= 1'b0;
        ex_regwrite_o <= 1'b0;
        ex_jump_o     <= 1'b0;
        ex_branch_o   <= 1'b0;
        ex_brtype_o   <= 1'b0;
        ex_memread_o  <= 1'b0;
        ex_memwrite_o <= 1'b0;
        ex_memtoreg_o <= 1'b0;
        ex_rt_o       <= '0;
        ex_wreg_o     <= '0;
      end else begin
        ex_valid_o    <= 1'b1;
        ex_aluop_o    <= ALUOP_W'(decCtrl.aluop);
        ex_alusrc_o   <= decCtrl.aluSrc;
        ex_regwrite_o <= decCtrl.regWrite;
        ex_jump_o     <= decCtrl.jump;
        ex_branch_o   <= decCtrl.branch;
        ex_brtype_o   <= decCtrl.brType;
        ex_memread_o  <= decCtrl.memRead;
        ex_memwrite_o <= decCtrl.memWrite;
        ex_memtoreg_o <= decCtrl.memToReg;
        ex_rt_o       <= id_rt_i;
        ex_wreg_o     <= decCtrl.regDst ? id_rd_i : id_rt_i;
      end
      if (id_valid_i & ~flush_i & ~hz & decIllegal)
        illegal_o <= 1'b1;
      if (stall_o && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: vector table plus hand sequences for reset, illegal and saturation.
module tb_decode_ctrl_stage;
  logic       clk = 1'b0;
  logic       rst;
  logic       idValid;
  logic [5:0] idOp;
  logic [4:0] idRs, idRt, idRd;
  logic       flush;

  logic        stall, exValid, exAlusrc, exRegwrite, exJump, exBranch, exBrtype;
  logic        exMemread, exMemwrite, exMemtoreg, illegal;
  logic [2:0]  exAluop;
  logic [4:0]  exRt, exWreg;
  logic [15:0] stallCnt;

  logic        sStall, sValid, sAlusrc, sRegwrite, sJump, sBranch, sBrtype;
  logic        sMemread, sMemwrite, sMemtoreg, sIllegal;
  logic [2:0]  sAluop;
  logic [4:0]  sRt, sWreg;
  logic [1:0]  sCnt;

  logic [7:0] ctlBits;
  assign ctlBits = {exAlusrc, exRegwrite, exJump, exBranch, exBrtype, exMemread, exMemwrite, exMemtoreg};

  int unsigned nComp = 0;
  int unsigned nFail = 0;

  always #5 clk = ~clk;

  decode_ctrl_stage dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(idValid), .id_op_i(idOp),
    .id_rs_i(idRs), .id_rt_i(idRt), .id_rd_i(idRd), .flush_i(flush),
    .stall_o(stall), .ex_valid_o(exValid), .ex_aluop_o(exAluop),
    .ex_alusrc_o(exAlusrc), .ex_regwrite_o(exRegwrite), .ex_jump_o(exJump),
    .ex_branch_o(exBranch), .ex_brtype_o(exBrtype), .ex_memread_o(exMemread),
    .ex_memwrite_o(exMemwrite), .ex_memtoreg_o(exMemtoreg), .ex_rt_o(exRt),
    .ex_wreg_o(exWreg), .illegal_o(illegal), .stall_cnt_o(stallCnt)
  );

  decode_ctrl_stage #(.CNT_W(2)) dutSat (
    .clk_i(clk), .rst_i(rst), .id_valid_i(idValid), .id_op_i(idOp),
    .id_rs_i(idRs), .id_rt_i(idRt), .id_rd_i(idRd), .flush_i(flush),
    .stall_o(sStall), .ex_valid_o(sValid), .ex_aluop_o(sAluop),
    .ex_alusrc_o(sAlusrc), .ex_regwrite_o(sRegwrite), .ex_jump_o(sJump),
    .ex_branch_o(sBranch), .ex_brtype_o(sBrtype), .ex_memread_o(sMemread),
    .ex_memwrite_o(sMemwrite), .ex_memtoreg_o(sMemtoreg), .ex_rt_o(sRt),
    .ex_wreg_o(sWreg), .illegal_o(sIllegal), .stall_cnt_o(sCnt)
  );

  typedef struct {
    logic       v;
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic       fl;
    logic       eStall;
    logic       eValid;
    logic [2:0] eAlu;
    logic [7:0] eCtl;
    logic [4:0] eRt, eWreg;
    logic       eIll;
    logic [15:0] eCnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nComp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs, rt, rd,
                       input logic fl);
    @(negedge clk);
    idValid = v; idOp = op; idRs = rs; idRt = rt; idRd = rd; flush = fl;
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic [5:0] op, input logic [4:0] rs, rt, rd,
                              input logic fl, input logic eStall, input logic eValid,
                              input logic [2:0] eAlu, input logic [7:0] eCtl,
                              input logic [4:0] eRt, eWreg, input logic eIll,
                              input logic [15:0] eCnt);
    vec_t r;
    r.v = v; r.op = op; r.rs = rs; r.rt = rt; r.rd = rd; r.fl = fl;
    r.eStall = eStall; r.eValid = eValid; r.eAlu = eAlu; r.eCtl = eCtl;
    r.eRt = eRt; r.eWreg = eWreg; r.eIll = eIll; r.eCnt = eCnt;
    return r;
  endfunction

  localparam logic [5:0] R = 6'b000000, ADDI = 6'b010011, LW = 6'b011000, SW = 6'b101000;
  localparam logic [5:0] BEQ = 6'b011001, BNE = 6'b011010, J = 6'b001100, BAD = 6'b111111;

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    idValid = 1'b1; idOp = 6'($urandom); idRs = 5'($urandom); idRt = 5'($urandom);
    idRd = 5'($urandom); flush = 1'($urandom);
    @(posedge clk);
    idOp = 6'($urandom); idRs = 5'($urandom);
    @(posedge clk); #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_valid", 32'(exValid), 0);
    chk("rst_ctl", 32'({exAluop, ctlBits}), 0);
    chk("rst_regs", 32'({exRt, exWreg}), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_cnt", 32'(stallCnt), 0);
    @(negedge clk);
    rst = 1'b0; idValid = 1'b0; flush = 1'b0;

    //              v  op    rs  rt  rd fl  stl vld alu     ctl           rt  wreg ill cnt
    vecs.push_back(mk(1, R,    1,  3,  7, 0, 0, 1, 3'b010, 8'b01000000,  3,  7, 0, 0));
    vecs.push_back(mk(1, ADDI, 2,  4,  9, 0, 0, 1, 3'b000, 8'b11000000,  4,  4, 0, 0));
    vecs.push_back(mk(1, LW,   1,  3,  0, 0, 0, 1, 3'b000, 8'b11000101,  3,  3, 0, 0));
    vecs.push_back(mk(1, SW,   2,  6,  1, 0, 0, 1, 3'b000, 8'b10000010,  6,  6, 0, 0));
    vecs.push_back(mk(1, BEQ,  6,  7,  1, 0, 0, 1, 3'b100, 8'b00010000,  7,  7, 0, 0));
    vecs.push_back(mk(1, BNE,  1,  2,  1, 0, 0, 1, 3'b100, 8'b00011000,  2,  2, 0, 0));
    vecs.push_back(mk(1, J,    0,  0,  0, 0, 0, 1, 3'b011, 8'b10100000,  0,  0, 0, 0));
    vecs.push_back(mk(0, R,    1,  2,  3, 0, 0, 0, 3'b000, 8'b00000000,  0,  0, 0, 0));
    // load-use on rs
    vecs.push_back(mk(1, LW,   1,  5,  0, 0, 0, 1, 3'b000, 8'b11000101,  5,  5, 0, 0));
    vecs.push_back(mk(1, R,    5,  2,  8, 0, 1, 0, 3'b000, 8'b00000000,  0,  0, 0, 1));
    vecs.push_back(mk(1, R,    5,  2,  8, 0, 0, 1, 3'b010, 8'b01000000,  2,  8, 0, 1));
    // $zero never stalls
    vecs.push_back(mk(1, LW,   0,  0,  0, 0, 0, 1, 3'b000, 8'b11000101,  0,  0, 0, 1));
    vecs.push_back(mk(1, R,    0,  0,  4, 0, 0, 1, 3'b010, 8'b01000000,  0,  4, 0, 1));
    // load-use on rt of a store
    vecs.push_back(mk(1, LW,   1,  9,  0, 0, 0, 1, 3'b000, 8'b11000101,  9,  9, 0, 1));
    vecs.push_back(mk(1, SW,   2,  9,  0, 0, 1, 0, 3'b000, 8'b00000000,  0,  0, 0, 2));
    vecs.push_back(mk(1, SW,   2,  9,  0, 0, 0, 1, 3'b000, 8'b10000010,  9,  9, 0, 2));
    // addi ignores rt match
    vecs.push_back(mk(1, LW,   1,  4,  0, 0, 0, 1, 3'b000, 8'b11000101,  4,  4, 0, 2));
    vecs.push_back(mk(1, ADDI, 1,  4,  0, 0, 0, 1, 3'b000, 8'b11000000,  4,  4, 0, 2));
    // flush beats stall
    vecs.push_back(mk(1, LW,   1,  5,  0, 0, 0, 1, 3'b000, 8'b11000101,  5,  5, 0, 2));
    vecs.push_back(mk(1, R,    5,  1,  3, 1, 0, 0, 3'b000, 8'b00000000,  0,  0, 0, 2));
    vecs.push_back(mk(1, R,    5,  1,  3, 0, 0, 1, 3'b010, 8'b01000000,  1,  3, 0, 2));
    // illegal: flushed or invalid does not set, valid does
    vecs.push_back(mk(1, BAD,  1,  2,  3, 1, 0, 0, 3'b000, 8'b00000000,  0,  0, 0, 2));
    vecs.push_back(mk(0, BAD,  1,  2,  3, 0, 0, 0, 3'b000, 8'b00000000,  0,  0, 0, 2));
    vecs.push_back(mk(1, BAD,  1,  2,  3, 0, 0, 0, 3'b000, 8'b00000000,  0,  0, 1, 2));

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].fl);
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].eStall));
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(exValid), 32'(vecs[i].eValid));
      chk($sformatf("v%0d_aluop", i), 32'(exAluop), 32'(vecs[i].eAlu));
      chk($sformatf("v%0d_ctl", i), 32'(ctlBits), 32'(vecs[i].eCtl));
      chk($sformatf("v%0d_rt", i), 32'(exRt), 32'(vecs[i].eRt));
      chk($sformatf("v%0d_wreg", i), 32'(exWreg), 32'(vecs[i].eWreg));
      chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].eIll));
      chk($sformatf("v%0d_cnt", i), 32'(stallCnt), 32'(vecs[i].eCnt));
    end

    // Sticky illegal across 10 legal instructions
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, ADDI, 5'd1, 5'(i + 1), 5'd0, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("sticky%0d_valid", i), 32'(exValid), 1);
      chk($sformatf("sticky%0d_illegal", i), 32'(illegal), 1);
    end

    // Reset coinciding with a stall
    drive(1'b1, LW, 5'd1, 5'd5, 5'd0, 1'b0);
    @(posedge clk);
    drive(1'b1, R, 5'd5, 5'd2, 5'd8, 1'b0);
    chk("midrst_stall_before", 32'(stall), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_stall_after", 32'(stall), 0);
    chk("midrst_valid", 32'(exValid), 0);
    chk("midrst_illegal", 32'(illegal), 0);
    chk("midrst_cnt", 32'(stallCnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // Saturation of a 2-bit counter over 5 stalls
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, LW, 5'd1, 5'd5, 5'd0, 1'b0);
      @(posedge clk);
      drive(1'b1, R, 5'd5, 5'd2, 5'd8, 1'b0);
      chk($sformatf("sat%0d_stall", i), 32'(sStall), 1);
      @(posedge clk); #1;
      chk($sformatf("sat%0d_cnt2", i), 32'(sCnt), (i + 1 > 3) ? 3 : i + 1);
      chk($sformatf("sat%0d_cnt16", i), 32'(stallCnt), 32'(i + 1));
    end
    drive(1'b0, R, 5'd0, 5'd0, 5'd0, 1'b0);
    @(posedge clk); #1;
    chk("sat_hold", 32'(sCnt), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
    $finish;
  end

endmodule
